tc_mul8_seq: RTL and testbench



---
 rtl/tc_mul8_seq.sv | 89 ++++++++
 tb/tb_tc_mul8_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tc_mul8_seq.sv
// Sequential two's-complement multiplier using radix-2 Booth recoding, one step per clock.
// Optional macro TC_MUL_ZERO_BYPASS_EN: zero operands skip iteration and report 0 immediately.
module tc_mul8_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     m,
  input  logic [WIDTH-1:0]     q,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH:0]     a, mr, a_sum, a_sh;
  logic [WIDTH-1:0]   qr, q_sh;
  logic               q_1;
  logic [CNT_W-1:0]   count;
  logic               accept, last_step, zero_op;

  assign accept    = start && (state == IDLE || state == DONE);
  assign last_step = (state == CALC) && (count == CNT_W'(WIDTH - 1));

`ifdef TC_MUL_ZERO_BYPASS_EN
  assign zero_op = (m == '0) || (q == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = zero_op ? DONE : CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = start ? (zero_op ? DONE : CALC) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add/subtract and arithmetic shift of {A,Q,Q_1} resolved in a single cycle.
  always_comb begin
    a_sum = a;
    unique case ({qr[0], q_1})
      2'b01:   a_sum = a + mr;
      2'b10:   a_sum = a - mr;
      default: a_sum = a;
    endcase
    a_sh = {a_sum[WIDTH], a_sum[WIDTH:1]};
    q_sh = {a_sum[0], qr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a     <= '0;
      mr    <= '0;
      qr    <= '0;
      q_1   <= 1'b0;
      count <= '0;
      p     <= '0;
    end else if (accept) begin
      mr    <= {m[WIDTH-1], m};
      qr    <= q;
      a     <= '0;
      q_1   <= 1'b0;
      count <= '0;
      if (zero_op) p <= '0;
    end else if (state == CALC) begin
      a     <= a_sh;
      qr    <= q_sh;
      q_1   <= qr[0];
      count <= count + 1'b1;
      if (last_step) p <= {a_sh[WIDTH-1:0], q_sh};
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_tc_mul8_seq.sv
// Scoreboard bench for tc_mul8_seq: expected products queued at issue, compared on each done strobe.
module tb_tc_mul8_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  m, q;
  logic        busy, done;
  logic [15:0] p;

  logic [15:0] sb[$];
  logic [15:0] held_p = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  tc_mul8_seq #(.WIDTH(8), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .m     (m),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    int r;
    r = $signed(a) * $signed(b);
    return r[15:0];
  endfunction

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef TC_MUL_ZERO_BYPASS_EN
    return (a == 8'h00 || b == 8'h00) ? 0 : 8;
`else
    if (a == b && a == 8'h01) return 8;
    return 8;
`endif
  endfunction

  // Output side: pop expectations on done, watch exclusivity and hold of p.
  always @(negedge clk) begin
    if (done) begin
      check_val("busy_done_excl", {31'b0, busy}, 32'h0);
      if (sb.size() == 0) begin
        check_val("unexpected_done", 32'h1, 32'h0);
      end else begin
        check_val("product", {16'h0, p}, {16'h0, sb.pop_front()});
      end
    end
    if (busy) check_val("p_held_while_busy", {16'h0, p}, {16'h0, held_p});
    else      held_p = p;
  end

  // Waits for done after the acceptance edge, checking latency and busy cycle count.
  task automatic wait_done(input string tag, input int lat_e);
    int lat, nbusy;
    lat = 0;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, "_latency"}, lat, lat_e);
    check_val({tag, "_busy_cycles"}, nbusy, lat_e);
  endtask

  task automatic do_op(input string tag, input logic [7:0] mm, input logic [7:0] qq);
    m = mm;
    q = qq;
    start = 1'b1;
    sb.push_back(prod(mm, qq));
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(tag, exp_lat(mm, qq));
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0;
    start = 1'b1;
    m = 8'h05;
    q = 8'h03;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_val("rst_busy", {31'b0, busy}, 32'h0);
      check_val("rst_done", {31'b0, done}, 32'h0);
      check_val("rst_p", {16'h0, p}, 32'h0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("basic", 8'h03, 8'h05);
    do_op("neg1", 8'hFF, 8'h01);
    do_op("min_min", 8'h80, 8'h80);
    do_op("min_max", 8'h80, 8'h7F);
    do_op("max_max", 8'h7F, 8'h7F);
    @(posedge clk); #1;

    // Back-to-back with operand change mid-iteration.
    m = 8'h02;
    q = 8'h06;
    start = 1'b1;
    sb.push_back(16'h000C);
    sb.push_back(16'hFFF4);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    m = 8'h04;
    q = 8'hFD;
    wait_done("b2b_first", 5);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b_second", 8);
    @(posedge clk); #1;

    // Reset during iteration discards the operation.
    m = 8'h7F;
    q = 8'h7F;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("midrst_busy", {31'b0, busy}, 32'h0);
    check_val("midrst_done", {31'b0, done}, 32'h0);
    check_val("midrst_p", {16'h0, p}, 32'h0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check_val("midrst_no_done", ndone, 0);
    do_op("after_rst", 8'h02, 8'h03);

    do_op("zero", 8'h00, 8'h9C);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] rm, rq;
      rm = 8'($random);
      rq = 8'($random);
      do_op("random", rm, rq);
    end

    repeat (3) @(posedge clk);
    #1;
    check_val("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
